ika9958_mem_slot_sched: RTL and testbench
=========================================

// Module: ika9958_mem_slot_sched
// PURPOSE
//  Memory-PLA stage, directly downstream of the common PLA / cpc counter. Consumes the registered
//  cpc modulo-8 strobes (z_of_m8c) and turns each 8-strobe access slot into one DRAM cycle.
//  Per slot: arbitrates display fetch, refresh, CPU and command-engine requests, then sequences
//  RAS/CAS/WE and acks the granted requester. Feeds the DRAM pad/address-mux stage.
// PARAMETERS
//  RFSH_PERIOD  16  slot starts between refresh requests (>=2)
//  CMD_STARVE   4   consecutive free slots CMD may lose to CPU before CMD is forced ahead of CPU
// PORTS
//  phiA          in   1  master clock; all state updates on posedge phiA
//  RST_async_n   in   1  asynchronous active-low reset
//  phiL_NCEN     in   1  clock enable; state advances only on phiA edges where this is 1
//  m8c           in   8  z_of_m8c strobes from cpc PLA, at most one bit set
//  disp_active   in   1  display fetch window
//  refresh_en    in   1  0 = refresh timer and pending cleared/held
//  cpu_req       in   1  CPU access request, level, held until cpu_ack
//  cpu_wr        in   1  CPU write (1) / read (0), valid while cpu_req
//  cmd_req       in   1  command-engine request, level, held until cmd_ack
//  cmd_wr        in   1  command write/read, valid while cmd_req
//  owner         out  3  0 IDLE, 1 DISP, 2 RFSH, 3 CPU, 4 CMD
//  ras_n         out  1  DRAM RAS, active low
//  cas_n         out  1  DRAM CAS, active low
//  we_n          out  1  DRAM WE, active low
//  cpu_ack       out  1  one-enabled-cycle pulse: CPU access done
//  cmd_ack       out  1  one-enabled-cycle pulse: CMD access done
//  rfsh_addr     out  8  refresh row counter
//  rfsh_overrun  out  1  one-enabled-cycle pulse: period expired with refresh still pending
//  slot_abort    out  1  one-enabled-cycle pulse: slot restarted mid-cycle
// BEHAVIOUR
//  Reset: owner=0, ras_n=cas_n=we_n=1, acks/pulses=0, rfsh_addr=0, timer=0, pending=0, busy=0, starve=0.
//  All registers are outputs of flops updated on the enabled edge where m8c[k] is sampled ("at k").
//  Edges with m8c=0 (text-mode cycles 8..11) hold all state; pulses return to 0.
//  k=0 (slot start), grant in priority order:
//   - DISP if disp_active and slot starts at cpc z=0 (first k=0 after previous k=7 or after an
//     8-cycle gap is not distinguishable; rule: DISP on alternate slot starts, text mode every start)
//   - else RFSH if refresh pending
//   - else CMD if cmd_req and starve==CMD_STARVE
//   - else CPU if cpu_req; else CMD if cmd_req; else IDLE
//   Owner and a write flag are registered; busy<=1 if owner!=IDLE.
//  Alternate-slot tracking: toggle bit cleared on entering disp_active and in text mode; DISP
//   when toggle==0. Graphics: 2 slots per 16 px, second is free.
//  Starve counter: +1 (saturating at CMD_STARVE) when CPU is granted while cmd_req=1.
//   Cleared on CMD grant or when cmd_req=0.
//  Refresh timer counts k=0 edges. At RFSH_PERIOD-1 it wraps to 0 and sets pending.
//   If pending is already 1 at that point: pending stays 1 and rfsh_overrun pulses.
//   Pending clears when RFSH is granted.
//  Sequence (busy only):
//   k=1 ras_n<=0; k=2 we_n<=0 if write; k=3 cas_n<=0 (not RFSH).
//   RFSH: k=5 ras_n<=1 and rfsh_addr+=1 (wraps 255->0).
//   Others: k=6 cas_n<=1, we_n<=1, ack pulse for CPU/CMD; k=7 ras_n<=1.
//   k=7 clears busy; owner returns to IDLE.
//  DISP/IDLE issue no ack. DISP is always a read.
//  Abort: k=0 while busy (cpc reload) -> ras_n/cas_n/we_n<=1 on that edge, slot_abort pulses,
//   no ack, pending requests remain and are re-arbitrated on the same edge.
//  Requester dropping req mid-slot: cycle completes, ack still pulses.
//  Reset mid-slot: immediate return to reset values. An aborted refresh keeps pending=1.
// TESTING
//  1 Reset, refresh_en=0, cpu_req=1 wr=0, m8c walk 0..7 -> owner=3 after k0, ras_n low k1..k6,
//    cas_n low k3..k5, we_n=1, cpu_ack pulse at k6.
//  2 refresh_en=1, RFSH_PERIOD=16, no reqs -> RFSH on slot 17, ras_n low k1..k4 only,
//    rfsh_addr 0->1; 256 refreshes -> wraps to 0.
//  3 cpu_req and cmd_req held high -> CPU, CPU, CPU, CPU, then CMD on 5th free slot, starve reset.
//  4 graphics, disp_active=1 -> slot starts alternate DISP/CPU;
//    text mode -> every slot DISP, CPU never acked.
//  5 CPU slot, inject m8c[0] at k=4 -> slot_abort=1, strobes high, no ack, CPU re-granted and
//    acked in the next slot.
//  6 refresh_en=1 with disp_active text mode held across 2 periods -> rfsh_overrun pulse once.

Source files
------------

// File: rtl/ika9958_mem_slot_sched.sv
// Memory-slot scheduler: turns each 8-strobe cpc access slot into one arbitrated DRAM cycle.
// Grants display/refresh/CPU/CMD at k=0, then sequences RAS/CAS/WE and acks the winner.
module ika9958_mem_slot_sched #(
  parameter int RFSH_PERIOD = 16,
  parameter int CMD_STARVE  = 4
) (
  input  logic       phiA,
  input  logic       RST_async_n,
  input  logic       phiL_NCEN,
  input  logic [7:0] m8c,
  input  logic       disp_active,
  input  logic       refresh_en,
  input  logic       cpu_req,
  input  logic       cpu_wr,
  input  logic       cmd_req,
  input  logic       cmd_wr,
  output logic [2:0] owner,
  output logic       ras_n,
  output logic       cas_n,
  output logic       we_n,
  output logic       cpu_ack,
  output logic       cmd_ack,
  output logic [7:0] rfsh_addr,
  output logic       rfsh_overrun,
  output logic       slot_abort
);

  localparam int TW = (RFSH_PERIOD > 2) ? $clog2(RFSH_PERIOD) : 1;
  localparam int SW = $clog2(CMD_STARVE + 1);
  localparam logic [2:0] OW_IDLE = 3'd0;
  localparam logic [2:0] OW_DISP = 3'd1;
  localparam logic [2:0] OW_RFSH = 3'd2;
  localparam logic [2:0] OW_CPU  = 3'd3;
  localparam logic [2:0] OW_CMD  = 3'd4;
  localparam logic [TW-1:0] TMR_LAST  = TW'(RFSH_PERIOD - 1);
  localparam logic [SW-1:0] STARVE_MX = SW'(CMD_STARVE);

  logic [2:0]    r_owner, w_owner, w_grant;
  logic          r_wr, w_wr, r_busy, w_busy;
  logic          r_ras_n, w_ras_n, r_cas_n, w_cas_n, r_we_n, w_we_n;
  logic          r_cpu_ack, w_cpu_ack, r_cmd_ack, w_cmd_ack;
  logic          r_overrun, w_overrun, r_abort, w_abort;
  logic [7:0]    r_raddr, w_raddr;
  logic [TW-1:0] r_timer, w_timer;
  logic          r_pend, w_pend, w_pend_eff, w_wrap;
  logic [SW-1:0] r_starve, w_starve;
  logic          r_tog, w_tog, w_tog_eff;
  logic          r_disp_prev, w_disp_prev;
  logic          r_gap, w_gap, w_text;

  // State register
  always_ff @(posedge phiA or negedge RST_async_n) begin
    if (!RST_async_n) begin
      r_owner     <= OW_IDLE;
      r_wr        <= 1'b0;
      r_busy      <= 1'b0;
      r_ras_n     <= 1'b1;
      r_cas_n     <= 1'b1;
      r_we_n      <= 1'b1;
      r_cpu_ack   <= 1'b0;
      r_cmd_ack   <= 1'b0;
      r_overrun   <= 1'b0;
      r_abort     <= 1'b0;
      r_raddr     <= '0;
      r_timer     <= '0;
      r_pend      <= 1'b0;
      r_starve    <= '0;
      r_tog       <= 1'b0;
      r_disp_prev <= 1'b0;
      r_gap       <= 1'b0;
    end else if (phiL_NCEN) begin
      r_owner     <= w_owner;
      r_wr        <= w_wr;
      r_busy      <= w_busy;
      r_ras_n     <= w_ras_n;
      r_cas_n     <= w_cas_n;
      r_we_n      <= w_we_n;
      r_cpu_ack   <= w_cpu_ack;
      r_cmd_ack   <= w_cmd_ack;
      r_overrun   <= w_overrun;
      r_abort     <= w_abort;
      r_raddr     <= w_raddr;
      r_timer     <= w_timer;
      r_pend      <= w_pend;
      r_starve    <= w_starve;
      r_tog       <= w_tog;
      r_disp_prev <= w_disp_prev;
      r_gap       <= w_gap;
    end
  end

  // Next state: arbitration at k=0, strobe sequencing at k=1..7
  always_comb begin
    w_owner     = r_owner;
    w_wr        = r_wr;
    w_busy      = r_busy;
    w_ras_n     = r_ras_n;
    w_cas_n     = r_cas_n;
    w_we_n      = r_we_n;
    w_cpu_ack   = 1'b0;
    w_cmd_ack   = 1'b0;
    w_overrun   = 1'b0;
    w_abort     = 1'b0;
    w_raddr     = r_raddr;
    w_timer     = r_timer;
    w_pend      = r_pend;
    w_starve    = r_starve;
    w_tog       = r_tog;
    w_disp_prev = r_disp_prev;
    w_gap       = r_gap;
    w_grant     = OW_IDLE;
    w_pend_eff  = 1'b0;
    w_wrap      = 1'b0;
    w_tog_eff   = 1'b0;
    // A strobe-free edge since the last slot start means 12-cycle text-mode slots
    w_text      = r_gap;

    if (m8c == 8'h00) begin
      w_gap = 1'b1;
    end else begin
      if (!cmd_req) w_starve = '0;
      if (m8c[0]) begin
        w_abort    = r_busy;
        w_ras_n    = 1'b1;
        w_cas_n    = 1'b1;
        w_we_n     = 1'b1;
        // An interrupted refresh is still owed
        w_pend_eff = refresh_en & (r_pend | (r_busy & (r_owner == OW_RFSH)));
        w_tog_eff  = r_disp_prev & ~w_text & r_tog;
        if (disp_active && !w_tog_eff)                w_grant = OW_DISP;
        else if (w_pend_eff)                          w_grant = OW_RFSH;
        else if (cmd_req && (r_starve == STARVE_MX))  w_grant = OW_CMD;
        else if (cpu_req)                             w_grant = OW_CPU;
        else if (cmd_req)                             w_grant = OW_CMD;
        w_owner     = w_grant;
        w_busy      = (w_grant != OW_IDLE);
        w_wr        = ((w_grant == OW_CPU) & cpu_wr) | ((w_grant == OW_CMD) & cmd_wr);
        w_tog       = disp_active & ~w_text & ~w_tog_eff;
        w_disp_prev = disp_active;
        w_gap       = 1'b0;
        if ((w_grant == OW_CMD) || !cmd_req)                    w_starve = '0;
        else if ((w_grant == OW_CPU) && (r_starve != STARVE_MX)) w_starve = r_starve + SW'(1);
        if (refresh_en) begin
          w_wrap  = (r_timer == TMR_LAST);
          w_timer = w_wrap ? '0 : r_timer + TW'(1);
          w_pend  = w_pend_eff & (w_grant != OW_RFSH);
          if (w_wrap) begin
            w_overrun = w_pend;
            w_pend    = 1'b1;
          end
        end
      end else if (r_busy) begin
        case (m8c)
          8'h02: w_ras_n = 1'b0;
          8'h04: if (r_wr) w_we_n = 1'b0;
          8'h08: if (r_owner != OW_RFSH) w_cas_n = 1'b0;
          8'h20: if (r_owner == OW_RFSH) begin
            w_ras_n = 1'b1;
            w_raddr = r_raddr + 8'd1;
          end
          8'h40: if (r_owner != OW_RFSH) begin
            w_cas_n   = 1'b1;
            w_we_n    = 1'b1;
            w_cpu_ack = (r_owner == OW_CPU);
            w_cmd_ack = (r_owner == OW_CMD);
          end
          8'h80: begin
            w_ras_n = 1'b1;
            w_busy  = 1'b0;
            w_owner = OW_IDLE;
          end
          default: ;
        endcase
      end
      if (!refresh_en) begin
        w_timer = '0;
        w_pend  = 1'b0;
      end
    end
  end

  // Outputs are straight from flops
  always_comb begin
    owner        = r_owner;
    ras_n        = r_ras_n;
    cas_n        = r_cas_n;
    we_n         = r_we_n;
    cpu_ack      = r_cpu_ack;
    cmd_ack      = r_cmd_ack;
    rfsh_addr    = r_raddr;
    rfsh_overrun = r_overrun;
    slot_abort   = r_abort;
  end

endmodule

// File: tb/tb_ika9958_mem_slot_sched.sv
// Directed bench for the memory-slot scheduler: vector table plus multi-slot sequences.
module tb_ika9958_mem_slot_sched;

  logic       phiA = 1'b0;
  logic       RST_async_n = 1'b0;
  logic       phiL_NCEN = 1'b1;
  logic [7:0] m8c = 8'h00;
  logic       disp_active = 1'b0;
  logic       refresh_en = 1'b0;
  logic       cpu_req = 1'b0;
  logic       cpu_wr = 1'b0;
  logic       cmd_req = 1'b0;
  logic       cmd_wr = 1'b0;
  logic [2:0] owner;
  logic       ras_n, cas_n, we_n, cpu_ack, cmd_ack, rfsh_overrun, slot_abort;
  logic [7:0] rfsh_addr;

  ika9958_mem_slot_sched #(.RFSH_PERIOD(16), .CMD_STARVE(4)) dut (
    .phiA(phiA), .RST_async_n(RST_async_n), .phiL_NCEN(phiL_NCEN), .m8c(m8c),
    .disp_active(disp_active), .refresh_en(refresh_en),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cmd_req(cmd_req), .cmd_wr(cmd_wr),
    .owner(owner), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
    .cpu_ack(cpu_ack), .cmd_ack(cmd_ack), .rfsh_addr(rfsh_addr),
    .rfsh_overrun(rfsh_overrun), .slot_abort(slot_abort)
  );

  always #5 phiA = ~phiA;

  typedef struct packed {
    logic       en;
    logic [7:0] m;
    logic       cr, cw, mr, mw;
    logic [2:0] o;
    logic [5:0] s; // {ras_n, cas_n, we_n, cpu_ack, cmd_ack, slot_abort}
  } vec_t;

  vec_t tv[$];
  int n_tests = 0, n_fail = 0;
  int n_cpu_ack, n_cmd_ack, n_ovr, n_rfsh;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic en, input logic [7:0] m, input logic cr, input logic cw,
                     input logic mr, input logic mw, input logic [2:0] o, input logic [5:0] s);
    vec_t v;
    v.en = en; v.m = m; v.cr = cr; v.cw = cw; v.mr = mr; v.mw = mw; v.o = o; v.s = s;
    tv.push_back(v);
  endtask

  task automatic tick(input logic [7:0] m);
    m8c = m;
    @(posedge phiA); #1;
    if (cpu_ack)      n_cpu_ack++;
    if (cmd_ack)      n_cmd_ack++;
    if (rfsh_overrun) n_ovr++;
  endtask

  task automatic slot(input int gap, output logic [2:0] own);
    tick(8'h01);
    own = owner;
    if (own == 3'd2) n_rfsh++;
    for (int k = 1; k < 8; k++) tick(8'h01 << k);
    for (int g = 0; g < gap; g++) tick(8'h00);
  endtask

  task automatic do_reset();
    RST_async_n = 1'b0;
    m8c = 8'h00;
    #3;
    RST_async_n = 1'b1;
    n_cpu_ack = 0; n_cmd_ack = 0; n_ovr = 0; n_rfsh = 0;
  endtask

  initial begin
    logic [2:0]  own;
    logic [17:0] seq;
    int          early;

    // CPU read slot with an idle-gap edge before k7
    add(1, 8'h01, 1, 0, 0, 0, 3'd3, 6'b111000);
    add(1, 8'h02, 1, 0, 0, 0, 3'd3, 6'b011000);
    add(1, 8'h04, 1, 0, 0, 0, 3'd3, 6'b011000);
    add(1, 8'h08, 1, 0, 0, 0, 3'd3, 6'b001000);
    add(1, 8'h10, 1, 0, 0, 0, 3'd3, 6'b001000);
    add(1, 8'h20, 1, 0, 0, 0, 3'd3, 6'b001000);
    add(1, 8'h40, 1, 0, 0, 0, 3'd3, 6'b011100);
    add(1, 8'h00, 1, 0, 0, 0, 3'd3, 6'b011000);
    add(1, 8'h80, 1, 0, 0, 0, 3'd0, 6'b111000);
    // CMD write slot
    add(1, 8'h01, 0, 0, 1, 1, 3'd4, 6'b111000);
    add(1, 8'h02, 0, 0, 1, 1, 3'd4, 6'b011000);
    add(1, 8'h04, 0, 0, 1, 1, 3'd4, 6'b010000);
    add(1, 8'h08, 0, 0, 1, 1, 3'd4, 6'b000000);
    add(1, 8'h10, 0, 0, 1, 1, 3'd4, 6'b000000);
    add(1, 8'h20, 0, 0, 1, 1, 3'd4, 6'b000000);
    add(1, 8'h40, 0, 0, 1, 1, 3'd4, 6'b011010);
    add(1, 8'h80, 0, 0, 1, 1, 3'd0, 6'b111000);
    // CPU write aborted at k4, disabled edge holds, re-granted, req dropped mid-slot
    add(1, 8'h01, 1, 1, 0, 0, 3'd3, 6'b111000);
    add(1, 8'h02, 1, 1, 0, 0, 3'd3, 6'b011000);
    add(1, 8'h04, 1, 1, 0, 0, 3'd3, 6'b010000);
    add(1, 8'h08, 1, 1, 0, 0, 3'd3, 6'b000000);
    add(1, 8'h01, 1, 1, 0, 0, 3'd3, 6'b111001);
    add(0, 8'h02, 1, 1, 0, 0, 3'd3, 6'b111001);
    add(1, 8'h02, 1, 1, 0, 0, 3'd3, 6'b011000);
    add(1, 8'h04, 1, 1, 0, 0, 3'd3, 6'b010000);
    add(1, 8'h08, 1, 1, 0, 0, 3'd3, 6'b000000);
    add(1, 8'h10, 0, 1, 0, 0, 3'd3, 6'b000000);
    add(1, 8'h20, 0, 1, 0, 0, 3'd3, 6'b000000);
    add(1, 8'h40, 0, 1, 0, 0, 3'd3, 6'b011100);
    add(1, 8'h80, 0, 1, 0, 0, 3'd0, 6'b111000);

    #12;
    check("reset_state", {owner, ras_n, cas_n, we_n, cpu_ack, cmd_ack, rfsh_overrun, slot_abort, rfsh_addr},
          {3'd0, 3'b111, 4'b0000, 8'd0});
    RST_async_n = 1'b1;

    for (int i = 0; i < tv.size(); i++) begin
      phiL_NCEN = tv[i].en; m8c = tv[i].m;
      cpu_req = tv[i].cr; cpu_wr = tv[i].cw; cmd_req = tv[i].mr; cmd_wr = tv[i].mw;
      @(posedge phiA); #1;
      check($sformatf("vec%0d", i), {owner, ras_n, cas_n, we_n, cpu_ack, cmd_ack, slot_abort},
            {tv[i].o, tv[i].s});
    end
    phiL_NCEN = 1'b1; cpu_req = 0; cpu_wr = 0; cmd_req = 0; cmd_wr = 0;

    // Asynchronous reset in the middle of a CPU slot
    cpu_req = 1;
    tick(8'h01); tick(8'h02); tick(8'h04); tick(8'h08);
    RST_async_n = 1'b0; #1;
    check("reset_mid_slot", {owner, ras_n, cas_n, we_n}, {3'd0, 3'b111});
    cpu_req = 0;
    do_reset();

    // Refresh: first grant on slot 17, RAS only k1..k4, row counter advances and wraps
    refresh_en = 1;
    early = 0;
    for (int s = 0; s < 16; s++) begin slot(0, own); if (own != 3'd0) early++; end
    check("no_early_rfsh", early, 0);
    tick(8'h01); check("rfsh_grant", owner, 3'd2);
    tick(8'h02); tick(8'h04); tick(8'h08);
    check("rfsh_k3", {ras_n, cas_n, we_n}, 3'b011);
    tick(8'h10); check("rfsh_k4", ras_n, 1'b0);
    tick(8'h20); check("rfsh_k5", {ras_n, rfsh_addr}, {1'b1, 8'd1});
    tick(8'h40); tick(8'h80);
    check("rfsh_k7", {owner, cpu_ack, cmd_ack}, 5'd0);
    n_rfsh = 0;
    for (int s = 0; s < 255 * 16; s++) slot(0, own);
    check("rfsh_count", n_rfsh, 255);
    check("rfsh_wrap", rfsh_addr, 8'd0);
    check("rfsh_no_overrun", n_ovr, 0);

    // Aborted refresh stays owed and is re-granted on the restart edge
    do_reset();
    for (int s = 0; s < 16; s++) slot(0, own);
    tick(8'h01); tick(8'h02); tick(8'h04);
    tick(8'h01);
    check("rfsh_abort", {owner, slot_abort, ras_n}, {3'd2, 1'b1, 1'b1});
    for (int k = 1; k < 8; k++) tick(8'h01 << k);
    check("rfsh_after_abort", rfsh_addr, 8'd1);
    refresh_en = 0;

    // CMD starvation: four CPU wins then CMD is forced through
    do_reset();
    cpu_req = 1; cmd_req = 1;
    seq = '0;
    for (int s = 0; s < 6; s++) begin slot(0, own); seq = {seq[14:0], own}; end
    check("starve_seq", seq, {3'd3, 3'd3, 3'd3, 3'd3, 3'd4, 3'd3});
    check("starve_acks", {n_cpu_ack[7:0], n_cmd_ack[7:0]}, {8'd5, 8'd1});
    cmd_req = 0;

    // Graphics display: alternate DISP / CPU
    do_reset();
    disp_active = 1;
    seq = '0;
    for (int s = 0; s < 4; s++) begin slot(0, own); seq = {seq[14:0], own}; end
    check("gfx_seq", seq[11:0], {3'd1, 3'd3, 3'd1, 3'd3});
    check("gfx_cpu_acks", n_cpu_ack, 2);

    // Text display: every slot DISP, CPU starved
    do_reset();
    seq = '0;
    for (int s = 0; s < 6; s++) begin slot(4, own); seq = {seq[14:0], own}; end
    check("text_seq", seq, {6{3'd1}});
    check("text_cpu_acks", n_cpu_ack, 0);
    cpu_req = 0;

    // Refresh held off by text display across two periods: one overrun
    do_reset();
    refresh_en = 1;
    for (int s = 0; s < 40; s++) slot(4, own);
    check("overrun_count", n_ovr, 1);
    check("overrun_no_rfsh", {n_rfsh[7:0], rfsh_addr}, 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
